// File: rtl/spi_cmd_ctrl.sv
// SPI command sequencer: decodes a read/write command byte, then streams bytes to/from a reg bus.
// Optional macro SPI_CMD_AUTOINC_EN: address auto-increments per data byte (else fixed FIFO port).
module spi_cmd_ctrl #(
    parameter int unsigned ADDR_W = 7
) (
    input  logic              ico_clk,
    input  logic              ico_rst_n,
    input  logic              sel_active,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic [7:0]        tx_byte,
    output logic              tx_valid,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    output logic              busy,
    output logic [7:0]        frame_count
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] CMD      = 3'd1;
    localparam logic [2:0] WR       = 3'd2;
    localparam logic [2:0] RD_FETCH = 3'd3;
    localparam logic [2:0] RD_WAIT  = 3'd4;
    localparam logic [2:0] RD_HOLD  = 3'd5;

    logic [2:0]        state_q, state_d;
    logic              sel_q;
    logic              got_data_q;
    logic              frame_end, byte_in, cmd_byte, wr_byte, hold_byte;
    logic [ADDR_W-1:0] addr_next;

`ifdef SPI_CMD_AUTOINC_EN
    assign addr_next = reg_addr + ADDR_W'(1);
`else
    assign addr_next = reg_addr;
`endif

    // Frame end takes priority over any byte arriving in the same cycle.
    assign frame_end = (state_q != IDLE) && !sel_active;
    assign byte_in   = rx_valid && sel_active;
    assign cmd_byte  = (state_q == CMD) && byte_in;
    assign wr_byte   = (state_q == WR) && byte_in;
    assign hold_byte = (state_q == RD_HOLD) && byte_in;

    always_comb begin
        state_d = state_q;
        if (frame_end) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:     if (sel_active && !sel_q) state_d = CMD;
                CMD:      if (rx_valid) state_d = rx_byte[7] ? RD_FETCH : WR;
                WR:       state_d = WR;
                RD_FETCH: state_d = RD_WAIT;
                RD_WAIT:  state_d = RD_HOLD;
                RD_HOLD:  if (rx_valid) state_d = RD_FETCH;
                default:  state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge ico_clk or negedge ico_rst_n) begin
        if (!ico_rst_n) begin
            state_q     <= IDLE;
            sel_q       <= 1'b0;
            got_data_q  <= 1'b0;
            busy        <= 1'b0;
            tx_byte     <= 8'h00;
            tx_valid    <= 1'b0;
            reg_addr    <= '0;
            reg_wdata   <= 8'h00;
            reg_we      <= 1'b0;
            reg_re      <= 1'b0;
            frame_count <= 8'h00;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_active;
            busy    <= (state_d != IDLE);
            reg_we  <= wr_byte;
            reg_re  <= (state_d == RD_FETCH) && (state_q != RD_FETCH);

            if (wr_byte) reg_wdata <= rx_byte;

            // Writes advance the cycle after the strobe; reads advance before the next fetch.
            if (cmd_byte) begin
                reg_addr <= rx_byte[ADDR_W-1:0];
            end else if (hold_byte || reg_we) begin
                reg_addr <= addr_next;
            end

            if (frame_end) begin
                tx_valid <= 1'b0;
            end else if (state_q == RD_WAIT) begin
                tx_byte  <= reg_rdata;
                tx_valid <= 1'b1;
            end else if (hold_byte) begin
                tx_valid <= 1'b0;
            end

            if (state_q == IDLE) begin
                got_data_q <= 1'b0;
            end else if (wr_byte || hold_byte) begin
                got_data_q <= 1'b1;
            end

            if (frame_end && got_data_q) frame_count <= frame_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed self-checking bench for spi_cmd_ctrl with a small register-file model on the bus.
module tb_spi_cmd_ctrl;

    logic       ico_clk;
    logic       ico_rst_n;
    logic       sel_active;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       busy;
    logic [7:0] frame_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [14:0] we_log[$];
    int          re_count  = 0;
    int          strobe_err = 0;
    logic        prev_we = 1'b0;
    logic        prev_re = 1'b0;

    spi_cmd_ctrl #(.ADDR_W(7)) dut (
        .ico_clk     (ico_clk),
        .ico_rst_n   (ico_rst_n),
        .sel_active  (sel_active),
        .rx_valid    (rx_valid),
        .rx_byte     (rx_byte),
        .tx_byte     (tx_byte),
        .tx_valid    (tx_valid),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_we      (reg_we),
        .reg_re      (reg_re),
        .reg_rdata   (reg_rdata),
        .busy        (busy),
        .frame_count (frame_count)
    );

    initial ico_clk = 1'b0;
    always #5 ico_clk = ~ico_clk;

    function automatic logic [7:0] rom(input logic [6:0] a);
        case (a)
            7'd2:    rom = 8'h3C;
            7'd3:    rom = 8'h4D;
            default: rom = {1'b0, a} ^ 8'hA5;
        endcase
    endfunction

    // Register file model: read data one cycle after reg_re; logs writes and strobe violations.
    always @(posedge ico_clk) begin
        reg_rdata <= reg_re ? rom(reg_addr) : 8'h00;
        if (reg_we) we_log.push_back({reg_addr, reg_wdata});
        if (reg_re) re_count <= re_count + 1;
        if ((reg_we && reg_re) || (reg_we && prev_we) || (reg_re && prev_re))
            strobe_err <= strobe_err + 1;
        prev_we <= reg_we;
        prev_re <= reg_re;
    end

    task automatic tick();
        @(posedge ico_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_reset();
        ico_rst_n  = 1'b0;
        sel_active = 1'b0;
        rx_valid   = 1'b0;
        rx_byte    = 8'h00;
        repeat (2) tick();
        ico_rst_n = 1'b1;
        tick();
        n_tests++;
        if ({tx_byte, tx_valid, reg_addr, reg_wdata, reg_we, reg_re, busy, frame_count}
            !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_values got tx=%h v=%b a=%h wd=%h we=%b re=%b busy=%b fc=%h exp all 0",
                     tx_byte, tx_valid, reg_addr, reg_wdata, reg_we, reg_re, busy, frame_count);
        end
    endtask

    task automatic test_write_burst();
        int base = we_log.size();
        int re0  = re_count;
        logic [14:0] exp1 = {7'd5, 8'hA1};
`ifdef SPI_CMD_AUTOINC_EN
        logic [14:0] exp2 = {7'd6, 8'hB2};
`else
        logic [14:0] exp2 = {7'd5, 8'hB2};
`endif
        sel_active = 1'b1;
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_before_edge got %b exp 0", busy); end
        tick();
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_rise got %b exp 1", busy); end
        send_byte(8'h05);
        send_byte(8'hA1);
        send_byte(8'hB2);
        sel_active = 1'b0;
        tick();
        n_tests++;
        if (we_log.size() != base + 2) begin
            n_fail++;
            $display("FAIL wr_count got %0d exp %0d", we_log.size() - base, 2);
        end else begin
            n_tests++;
            if (we_log[base] !== exp1) begin
                n_fail++;
                $display("FAIL wr_first got %h exp %h", we_log[base], exp1);
            end
            n_tests++;
            if (we_log[base+1] !== exp2) begin
                n_fail++;
                $display("FAIL wr_second got %h exp %h", we_log[base+1], exp2);
            end
        end
        n_tests++;
        if (re_count != re0) begin n_fail++; $display("FAIL wr_no_re got %0d exp %0d", re_count, re0); end
        n_tests++;
        if (frame_count !== 8'd1) begin n_fail++; $display("FAIL wr_fcount got %0d exp 1", frame_count); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_busy_end got %b exp 0", busy); end
        repeat (3) tick();
    endtask

    task automatic test_read_burst();
        int base = we_log.size();
`ifdef SPI_CMD_AUTOINC_EN
        logic [7:0] exp_second = 8'h4D;
        logic [6:0] exp_addr2  = 7'd3;
`else
        logic [7:0] exp_second = 8'h3C;
        logic [6:0] exp_addr2  = 7'd2;
`endif
        sel_active = 1'b1;
        tick();
        rx_byte  = 8'h82;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        n_tests++;
        if (reg_re !== 1'b1 || reg_addr !== 7'd2) begin
            n_fail++;
            $display("FAIL rd_fetch got re=%b addr=%h exp re=1 addr=02", reg_re, reg_addr);
        end
        tick();
        n_tests++;
        if (reg_re !== 1'b0 || tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_wait got re=%b txv=%b exp 0 0", reg_re, tx_valid);
        end
        tick();
        n_tests++;
        if (tx_valid !== 1'b1 || tx_byte !== 8'h3C) begin
            n_fail++;
            $display("FAIL rd_first got txv=%b tx=%h exp 1 3c", tx_valid, tx_byte);
        end
        repeat (6) tick();
        rx_byte  = 8'h00;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        n_tests++;
        if (tx_valid !== 1'b0 || reg_re !== 1'b1 || reg_addr !== exp_addr2) begin
            n_fail++;
            $display("FAIL rd_dummy1 got txv=%b re=%b addr=%h exp 0 1 %h",
                     tx_valid, reg_re, reg_addr, exp_addr2);
        end
        repeat (2) tick();
        n_tests++;
        if (tx_valid !== 1'b1 || tx_byte !== exp_second) begin
            n_fail++;
            $display("FAIL rd_second got txv=%b tx=%h exp 1 %h", tx_valid, tx_byte, exp_second);
        end
        repeat (6) tick();
        send_byte(8'h00);
        sel_active = 1'b0;
        tick();
        n_tests++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || frame_count !== 8'd2) begin
            n_fail++;
            $display("FAIL rd_end got txv=%b busy=%b fc=%0d exp 0 0 2", tx_valid, busy, frame_count);
        end
        n_tests++;
        if (we_log.size() != base) begin
            n_fail++;
            $display("FAIL rd_no_we got %0d exp 0", we_log.size() - base);
        end
        repeat (3) tick();
    endtask

    task automatic test_addr_wrap();
        int base = we_log.size();
`ifdef SPI_CMD_AUTOINC_EN
        logic [14:0] exp2 = {7'h00, 8'h22};
`else
        logic [14:0] exp2 = {7'h7F, 8'h22};
`endif
        logic [14:0] exp1 = {7'h7F, 8'h11};
        sel_active = 1'b1;
        tick();
        send_byte(8'h7F);
        send_byte(8'h11);
        send_byte(8'h22);
        sel_active = 1'b0;
        tick();
        n_tests++;
        if (we_log.size() != base + 2) begin
            n_fail++;
            $display("FAIL wrap_count got %0d exp 2", we_log.size() - base);
        end else begin
            n_tests++;
            if (we_log[base] !== exp1) begin
                n_fail++;
                $display("FAIL wrap_first got %h exp %h", we_log[base], exp1);
            end
            n_tests++;
            if (we_log[base+1] !== exp2) begin
                n_fail++;
                $display("FAIL wrap_second got %h exp %h", we_log[base+1], exp2);
            end
        end
        n_tests++;
        if (frame_count !== 8'd3) begin n_fail++; $display("FAIL wrap_fcount got %0d exp 3", frame_count); end
        repeat (3) tick();
    endtask

    task automatic test_cmd_only();
        sel_active = 1'b1;
        tick();
        rx_byte  = 8'h83;
        rx_valid = 1'b1;
        tick();
        rx_valid   = 1'b0;
        sel_active = 1'b0;
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL cmd_busy got %b exp 1", busy); end
        tick();
        n_tests++;
        if (busy !== 1'b0 || tx_valid !== 1'b0 || frame_count !== 8'd3) begin
            n_fail++;
            $display("FAIL cmd_only got busy=%b txv=%b fc=%0d exp 0 0 3", busy, tx_valid, frame_count);
        end
        repeat (3) tick();
    endtask

    task automatic test_abort_reset();
        sel_active = 1'b1;
        tick();
        rx_byte  = 8'h82;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL abort_hold got txv=%b exp 1", tx_valid); end
        #2;
        ico_rst_n = 1'b0;
        #1;
        n_tests++;
        if ({tx_byte, tx_valid, reg_addr, reg_wdata, reg_we, reg_re, busy, frame_count}
            !== 35'd0) begin
            n_fail++;
            $display("FAIL abort_reset got tx=%h v=%b a=%h wd=%h we=%b re=%b busy=%b fc=%h exp all 0",
                     tx_byte, tx_valid, reg_addr, reg_wdata, reg_we, reg_re, busy, frame_count);
        end
        sel_active = 1'b0;
        #2;
        ico_rst_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_rx_with_sel_low();
        int base = we_log.size();
        sel_active = 1'b1;
        tick();
        send_byte(8'h01);
        rx_byte    = 8'h99;
        rx_valid   = 1'b1;
        sel_active = 1'b0;
        tick();
        rx_valid = 1'b0;
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL end_wins_busy got %b exp 0", busy); end
        repeat (3) tick();
        rx_byte  = 8'h55;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (we_log.size() != base || frame_count !== 8'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL end_wins got writes=%0d fc=%0d busy=%b exp 0 0 0",
                     we_log.size() - base, frame_count, busy);
        end
        n_tests++;
        if (strobe_err != 0) begin
            n_fail++;
            $display("FAIL strobe_rules got %0d violations exp 0", strobe_err);
        end
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_read_burst();
        test_addr_wrap();
        test_cmd_only();
        test_abort_reset();
        test_rx_with_sel_low();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_cmd_ctrl.md
# spi_cmd_ctrl

Command sequencer behind the icoboard SPI byte shifter. Interprets the first byte of each SPI frame from the Pi as a read/write command with a register address, then streams data bytes into, or out of, a synchronous register bus. Sits between the byte-level SPI datapath and the test-bench register file, all in the `ico_clk` domain.

## Interface

**Parameters**
- `ADDR_W`, default 7: register address width. Legal range 1–7. The command byte carries 7 address bits; only the low `ADDR_W` bits are used.

**Ports**
- `ico_clk` in 1: system clock; all logic rises on it.
- `ico_rst_n` in 1: asynchronous, active-low reset.
- `sel_active` in 1: frame active, already synchronized and active-high; low means SEL is deasserted.
- `rx_valid` in 1: one-cycle pulse; a complete byte is available on `rx_byte`.
- `rx_byte` in 8: received byte, MSB first as shifted.
- `tx_byte` out 8: next byte for the shifter to send.
- `tx_valid` out 1: `tx_byte` is valid for loading at the next byte boundary.
- `reg_addr` out ADDR_W: register bus address.
- `reg_wdata` out 8: register write data.
- `reg_we` out 1: one-cycle write strobe.
- `reg_re` out 1: one-cycle read strobe.
- `reg_rdata` in 8: read data, valid exactly one cycle after `reg_re`.
- `busy` out 1: high in any state other than IDLE.
- `frame_count` out 8: count of frames that completed with at least one data byte; wraps 255→0.

## Operation

- **Command byte:** bit7 = 1 means read, 0 means write; bits[ADDR_W-1:0] give the start address. Bits between ADDR_W and 6 are ignored.
- **States:** IDLE, CMD, WR, RD_FETCH, RD_WAIT, RD_HOLD.
- **IDLE → CMD** when `sel_active` rises.
- **CMD**, on `rx_valid`:
  - Latch the address.
  - Write command: go to WR.
  - Read command: go to RD_FETCH.
- **WR**, on each `rx_valid`:
  - Assert `reg_we` for 1 cycle with `reg_addr` = current address and `reg_wdata` = `rx_byte`.
  - Then advance the address.
- **RD_FETCH:** assert `reg_re` for 1 cycle, then go to RD_WAIT.
- **RD_WAIT:** capture `reg_rdata` into `tx_byte`, set `tx_valid`, go to RD_HOLD.
- **RD_HOLD**, on `rx_valid` (the dummy byte, meaning the previous tx byte was consumed):
  - Clear `tx_valid`.
  - Advance the address.
  - Go to RD_FETCH.
- **Address advance:** +1 modulo 2^ADDR_W, so 2^ADDR_W−1 wraps to 0.
- **Frame end:** `sel_active` low in any non-IDLE state forces IDLE on the next edge.
  - Clears `tx_valid`.
  - No `reg_we`/`reg_re` is issued in that cycle.
  - `frame_count` increments if at least one data byte (write or dummy) was received after the command.
- **Precedence:** `rx_valid` coincident with `sel_active` low is ignored; frame end wins.
- **Ignored inputs:** `rx_valid` in IDLE, RD_FETCH or RD_WAIT is ignored. The datapath guarantees ≥8 `ico_clk` cycles between bytes.

## Timing

- **Reset values:** state IDLE; `tx_byte` = 0x00; `tx_valid` = 0; `reg_addr` = 0; `reg_wdata` = 0; `reg_we` = 0; `reg_re` = 0; `busy` = 0; `frame_count` = 0.
- **Write latency:** `reg_we` asserts the cycle after `rx_valid`.
- **Read latency:**
  - `reg_re` is asserted the cycle after the command `rx_valid`.
  - `tx_valid` rises 2 cycles after `reg_re` (RD_WAIT, then registered output).
  - 3 cycles total from `rx_valid` to `tx_valid`, which is well within one SPI byte time.
- **Strobes:** `reg_we` and `reg_re` are never high together and never high for 2 consecutive cycles.
- **`busy`:** registered; rises the cycle after `sel_active` rises.
- **Reset mid-frame:** asynchronous return to reset values; no partial strobe is emitted.

## Configuration

- **`SPI_CMD_AUTOINC_EN` defined:** the address advances after every data byte, as described above.
- **`SPI_CMD_AUTOINC_EN` undefined:** the address stays fixed at the command address for the whole frame, which gives FIFO-port access. All other behaviour is unchanged.

## Test plan

- **Write burst:** frame with 0x05, 0xA1, 0xB2 → `reg_we` at addr 5 with data 0xA1, then addr 6 with data 0xB2; `frame_count` = 1 after SEL drops.
- **Read burst:** register file holds 0x3C at addr 2 and 0x4D at addr 3; frame 0x82, dummy, dummy → `tx_byte` 0x3C then 0x4D with `tx_valid` per byte; no `reg_we`.
- **Address wrap:** with ADDR_W = 7, write frame 0x7F, 0x11, 0x22 → writes at 0x7F then 0x00. With the macro undefined, both writes go to 0x7F.
- **Command-only frame:** SEL drops right after byte 0x83 → state returns to IDLE in 1 cycle; `tx_valid` = 0; `frame_count` unchanged.
- **Abort and reset:**
  - `ico_rst_n` pulsed low in RD_HOLD → all outputs return to reset values immediately.
  - `rx_valid` together with `sel_active` low → no strobe is issued.
